// File: rtl/pu_msp430_pkg.sv
// Shared definitions for the MSP430 RAM-side blocks: DMA state encoding and
// the low-active RAM control encodings.
package pu_msp430_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  localparam logic       CEN_OFF  = 1'b1;
  localparam logic [1:0] WEN_READ = 2'b11;
  localparam logic [1:0] WEN_WORD = 2'b00;

endpackage

// File: rtl/pu_msp430_ram_dp.sv
// Dual-port word RAM with per-byte low-active write enables and a registered
// read port; read data appears in the cycle after the read edge.
module pu_msp430_ram_dp
  import pu_msp430_pkg::*;
#(
  parameter int unsigned ADDR_MSB = 6,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic              ram_clk,
  input  logic [ADDR_MSB:0] ram_addra,
  input  logic              ram_cena,
  input  logic [1:0]        ram_wena,
  input  logic [15:0]       ram_dina,
  output logic [15:0]       ram_douta,
  input  logic [ADDR_MSB:0] ram_addrb,
  input  logic              ram_cenb,
  input  logic [1:0]        ram_wenb,
  input  logic [15:0]       ram_dinb,
  output logic [15:0]       ram_doutb
);

  localparam int unsigned DEPTH = MEM_SIZE / 2;

  logic [15:0] mem [0:DEPTH-1];

  // Both ports in one process so the array has a single driver.
  always_ff @(posedge ram_clk) begin
    if (ram_cena != CEN_OFF) begin
      if (ram_wena == WEN_READ) ram_douta <= mem[ram_addra];
      if (!ram_wena[0]) mem[ram_addra][7:0]  <= ram_dina[7:0];
      if (!ram_wena[1]) mem[ram_addra][15:8] <= ram_dina[15:8];
    end
    if (ram_cenb != CEN_OFF) begin
      if (ram_wenb == WEN_READ) ram_doutb <= mem[ram_addrb];
      if (!ram_wenb[0]) mem[ram_addrb][7:0]  <= ram_dinb[7:0];
      if (!ram_wenb[1]) mem[ram_addrb][15:8] <= ram_dinb[15:8];
    end
  end

endmodule

// File: rtl/pu_msp430_ram_dma.sv
// Word-granular RAM DMA engine: copy (read then write, 2 cycles/word) or
// fill (write pattern, 1 cycle/word) with abort and wrap-around addressing.
module pu_msp430_ram_dma
  import pu_msp430_pkg::*;
#(
  parameter int unsigned ADDR_MSB = 6,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                dma_start,
  input  logic                dma_abort,
  input  logic                dma_fill,
  input  logic [ADDR_MSB:0]   dma_src,
  input  logic [ADDR_MSB:0]   dma_dst,
  input  logic [ADDR_MSB+1:0] dma_len,
  input  logic [15:0]         dma_pattern,
  output logic                dma_busy,
  output logic                dma_done,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic                ram_cen,
  output logic [1:0]          ram_wen,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout
);

  localparam int unsigned AW    = ADDR_MSB + 1;
  localparam int unsigned LW    = ADDR_MSB + 2;
  localparam int unsigned DEPTH = MEM_SIZE / 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  dma_state_e    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic          fill_q, fill_d;
  logic [15:0]   pat_q, pat_d;

  // Addresses are modulo the word depth, which need not be a power of two.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= 1'b0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    dma_busy = 1'b0;
    dma_done = 1'b0;
    ram_addr = '0;
    ram_cen  = CEN_OFF;
    ram_wen  = WEN_READ;
    ram_din  = '0;

    unique case (state_q)
      IDLE: begin
        // Start wins over a simultaneous abort; abort alone is a no-op here.
        if (dma_start) begin
          src_d  = dma_src;
          dst_d  = dma_dst;
          len_d  = dma_len;
          fill_d = dma_fill;
          pat_d  = dma_pattern;
          if (dma_len == '0)  state_d = DONE;
          else if (dma_fill)  state_d = WR;
          else                state_d = RD;
        end
      end
      RD: begin
        dma_busy = 1'b1;
        ram_cen  = ~CEN_OFF;
        ram_addr = src_q;
        state_d  = dma_abort ? IDLE : WR;
      end
      WR: begin
        dma_busy = 1'b1;
        ram_cen  = ~CEN_OFF;
        ram_wen  = WEN_WORD;
        ram_addr = dst_q;
        ram_din  = fill_q ? pat_q : ram_dout;
        dst_d    = next_addr(dst_q);
        if (!fill_q) src_d = next_addr(src_q);
        len_d    = len_q - LW'(1);
        // The write at this edge lands regardless; abort only cancels the rest.
        if (dma_abort)              state_d = IDLE;
        else if (len_q == LW'(1))   state_d = DONE;
        else if (fill_q)            state_d = WR;
        else                        state_d = RD;
      end
      DONE: begin
        dma_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pu_msp430_ram_dma.sv
// Bench for pu_msp430_ram_dma against port A of pu_msp430_ram_dp; port B is
// used to preload and read back RAM contents.
module tb_pu_msp430_ram_dma;
  import pu_msp430_pkg::*;

  localparam int unsigned ADDR_MSB = 6;
  localparam int unsigned MEM_SIZE = 256;
  localparam int unsigned DEPTH    = MEM_SIZE / 2;

  logic        mclk = 1'b0;
  logic        puc_rst, dma_start, dma_abort, dma_fill;
  logic [6:0]  dma_src, dma_dst;
  logic [7:0]  dma_len;
  logic [15:0] dma_pattern;
  logic        dma_busy, dma_done;
  logic [6:0]  ram_addr;
  logic        ram_cen;
  logic [1:0]  ram_wen;
  logic [15:0] ram_din, ram_dout;
  logic [6:0]  b_addr;
  logic        b_cen;
  logic [1:0]  b_wen;
  logic [15:0] b_din, b_dout;

  always #5 mclk = ~mclk;

  pu_msp430_ram_dma #(.ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .dma_start(dma_start), .dma_abort(dma_abort),
    .dma_fill(dma_fill), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_pattern(dma_pattern), .dma_busy(dma_busy), .dma_done(dma_done),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  pu_msp430_ram_dp #(.ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE)) ram (
    .ram_clk(mclk),
    .ram_addra(ram_addr), .ram_cena(ram_cen), .ram_wena(ram_wen),
    .ram_dina(ram_din), .ram_douta(ram_dout),
    .ram_addrb(b_addr), .ram_cenb(b_cen), .ram_wenb(b_wen),
    .ram_dinb(b_din), .ram_doutb(b_dout)
  );

  typedef struct packed {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic        fill;
    logic [6:0]  src;
    logic [6:0]  dst;
    logic [7:0]  len;
    logic [15:0] pat;
    int          lat;
  } vec_t;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cen_cnt = 0;
  wr_t sb[$];
  logic [15:0] ref_mem [0:DEPTH-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RAM port-A monitor: every word write is matched against the scoreboard.
  always @(negedge mclk) begin
    if (dma_done) done_cnt++;
    if (!ram_cen) cen_cnt++;
    if (dma_busy || !ram_cen) check("busy_vs_cen", 32'(dma_busy), 32'(!ram_cen));
    if (!ram_cen && ram_wen != WEN_READ) begin
      check("wen_word", 32'(ram_wen), 32'(WEN_WORD));
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h", ram_addr, ram_din);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.a));
        check("wr_data", 32'(ram_din), 32'(e.d));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic write_word(input logic [6:0] a, input logic [15:0] d);
    b_addr = a; b_din = d; b_cen = 1'b0; b_wen = 2'b00;
    tick();
    b_cen = 1'b1; b_wen = 2'b11;
    ref_mem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      b_addr = 7'(a); b_cen = 1'b0; b_wen = 2'b11;
      tick();
      b_cen = 1'b1;
      check($sformatf("%s_mem[%02h]", tag, a), 32'(b_dout), 32'(ref_mem[a]));
    end
  endtask

  // Reference model: expected word writes in order, applied to ref_mem.
  task automatic push_expect(input logic f, input logic [6:0] s, input logic [6:0] d,
                             input int n, input logic [15:0] p);
    logic [6:0] sa, da;
    logic [15:0] w;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      w = f ? p : ref_mem[sa];
      sb.push_back('{a: da, d: w});
      ref_mem[da] = w;
      sa = sa + 7'd1;
      da = da + 7'd1;
    end
  endtask

  task automatic start_xfer(input logic f, input logic [6:0] s, input logic [6:0] d,
                            input logic [7:0] l, input logic [15:0] p);
    dma_fill = f; dma_src = s; dma_dst = d; dma_len = l; dma_pattern = p;
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
  endtask

  // Latency = number of edges after the start edge up to the edge that samples done.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 300 && lat == 0; c++) begin
      @(negedge mclk);
      if (dma_done) lat = c;
      else @(posedge mclk);
    end
    check(name, 32'(lat), 32'(exp_lat));
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cen"},  32'(ram_cen),  32'(1));
    check({tag, "_wen"},  32'(ram_wen),  32'(3));
    check({tag, "_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_din"},  32'(ram_din),  32'(0));
    check({tag, "_busy"}, 32'(dma_busy), 32'(0));
    check({tag, "_done"}, 32'(dma_done), 32'(0));
  endtask

  vec_t vecs[4];
  int c0, d0;

  initial begin
    vecs[0] = '{fill: 1'b0, src: 7'h10, dst: 7'h40, len: 8'd4, pat: 16'h0000, lat: 9};
    vecs[1] = '{fill: 1'b1, src: 7'h00, dst: 7'h20, len: 8'd3, pat: 16'h5A5A, lat: 4};
    vecs[2] = '{fill: 1'b0, src: 7'h30, dst: 7'h50, len: 8'd0, pat: 16'h0000, lat: 1};
    vecs[3] = '{fill: 1'b1, src: 7'h00, dst: 7'h7E, len: 8'd4, pat: 16'hC0DE, lat: 5};

    puc_rst = 1'b1; dma_start = 1'b0; dma_abort = 1'b0; dma_fill = 1'b0;
    dma_src = '0; dma_dst = '0; dma_len = '0; dma_pattern = '0;
    b_addr = '0; b_cen = 1'b1; b_wen = 2'b11; b_din = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    puc_rst = 1'b0;
    tick();

    for (int a = 0; a < int'(DEPTH); a++) write_word(7'(a), 16'hE000 | 16'(a));
    write_word(7'h10, 16'hA1A1);
    write_word(7'h11, 16'hB2B2);
    write_word(7'h12, 16'hC3C3);
    write_word(7'h13, 16'hD4D4);

    for (int i = 0; i < 4; i++) begin
      push_expect(vecs[i].fill, vecs[i].src, vecs[i].dst, int'(vecs[i].len), vecs[i].pat);
      c0 = cen_cnt; d0 = done_cnt;
      start_xfer(vecs[i].fill, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].pat);
      wait_done($sformatf("vec%0d_latency", i), vecs[i].lat);
      check($sformatf("vec%0d_cen_cycles", i), 32'(cen_cnt - c0),
            vecs[i].fill ? 32'(vecs[i].len) : 32'(2 * int'(vecs[i].len)));
      check($sformatf("vec%0d_done_pulses", i), 32'(done_cnt - d0), 32'(1));
      check($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'(0));
      check_mem($sformatf("vec%0d", i));
    end

    // Abort during the second write of a 4-word copy, then restart at once.
    push_expect(1'b0, 7'h10, 7'h60, 2, 16'h0);
    c0 = cen_cnt; d0 = done_cnt;
    start_xfer(1'b0, 7'h10, 7'h60, 8'd4, 16'h0);
    repeat (3) tick();
    dma_abort = 1'b1;
    tick();
    dma_abort = 1'b0;
    check("abort_busy_low", 32'(dma_busy), 32'(0));
    push_expect(1'b1, 7'h00, 7'h68, 1, 16'hABCD);
    start_xfer(1'b1, 7'h00, 7'h68, 8'd1, 16'hABCD);
    wait_done("restart_latency", 2);
    check("abort_done_pulses", 32'(done_cnt - d0), 32'(1));
    check("abort_cen_cycles", 32'(cen_cnt - c0), 32'(5));
    check("abort_sb_empty", 32'(sb.size()), 32'(0));
    check_mem("abort");

    // Start with abort held accepted; abort on the final write drops done.
    push_expect(1'b1, 7'h00, 7'h70, 2, 16'h3C3C);
    d0 = done_cnt;
    dma_abort = 1'b1;
    start_xfer(1'b1, 7'h00, 7'h70, 8'd2, 16'h3C3C);
    dma_abort = 1'b0;
    check("start_with_abort_busy", 32'(dma_busy), 32'(1));
    tick();
    dma_abort = 1'b1;
    tick();
    dma_abort = 1'b0;
    repeat (3) tick();
    check("final_abort_no_done", 32'(done_cnt - d0), 32'(0));
    check("final_abort_idle", 32'(dma_busy), 32'(0));
    check("final_abort_sb_empty", 32'(sb.size()), 32'(0));
    check_mem("final_abort");

    // Reset mid-fill: the write presented at the reset edge still lands.
    push_expect(1'b1, 7'h00, 7'h48, 3, 16'h7777);
    d0 = done_cnt;
    start_xfer(1'b1, 7'h00, 7'h48, 8'd6, 16'h7777);
    repeat (2) tick();
    puc_rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    puc_rst = 1'b0;
    repeat (3) tick();
    check("midreset_no_done", 32'(done_cnt - d0), 32'(0));
    check("midreset_sb_empty", 32'(sb.size()), 32'(0));
    check_mem("midreset");

    // A start while busy must not disturb the running fill.
    push_expect(1'b1, 7'h00, 7'h50, 3, 16'h1111);
    c0 = cen_cnt; d0 = done_cnt;
    start_xfer(1'b1, 7'h00, 7'h50, 8'd3, 16'h1111);
    dma_fill = 1'b0; dma_src = 7'h10; dma_dst = 7'h00; dma_len = 8'd1;
    dma_pattern = 16'hDEAD; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    wait_done("busy_start_latency", 3);
    check("busy_start_cen_cycles", 32'(cen_cnt - c0), 32'(3));
    check("busy_start_done_pulses", 32'(done_cnt - d0), 32'(1));
    check("busy_start_sb_empty", 32'(sb.size()), 32'(0));
    check_mem("busy_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
